// File: rtl/add_tree_pkg.sv
// Shared types and defaults for the lane-reduction adder tree sequencer.
// The state encoding and the tree-width check live here so every file agrees on them.
package add_tree_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_LANES = 12;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_SUM_W = 20;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_LEN_W = 8;

  // True when a SUM_W-bit tree output cannot overflow for the given lane count.
  function automatic bit sum_w_fits(input int lanes, input int in_w, input int sum_w);
    return sum_w >= in_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/add_tree_accum_ctrl_if.sv
// Operand-stream, result and config signals of the adder-tree sequencer.
// slave is the sequencer side; master is the producer/consumer side.
interface add_tree_accum_ctrl_if
  import add_tree_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
);

  logic [LEN_W-1:0]      cfg_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic                  out_overflow;
  logic                  busy;

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, busy
  );

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, busy
  );

endinterface

// File: rtl/add_tree_reduce.sv
// Combinational binary reduction of LANES unsigned lanes into one SUM_W sum.
// Each level pairs neighbours; an odd leftover lane passes straight to the next level.
module add_tree_reduce
  import add_tree_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic [LANES*IN_W-1:0] data,
  output logic [SUM_W-1:0]      sum
);

  localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int SLOTS  = LANES + (LANES % 2);

  // Number of live partial sums at a given tree level.
  function automatic int width_at(input int lvl);
    return (LANES + (1 << lvl) - 1) >> lvl;
  endfunction

  logic [SUM_W-1:0] node [SLOTS];

  // NOTE: every element is assigned before any branch reads it, so no latch can be inferred.
  // Reduction is done in place: slot i at level l+1 only reads slots 2i and 2i+1,
  // which are never overwritten earlier in the same level.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++) node[i] = SUM_W'(data[i*IN_W +: IN_W]);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < SLOTS / 2; i++) begin
        if (i < width_at(l + 1)) begin
          if (2 * i + 1 < width_at(l)) node[i] = node[2*i] + node[2*i+1];
          else                         node[i] = node[2*i];
        end
      end
    end
    sum = node[0];
  end

endmodule

// File: rtl/add_tree_accum_ctrl.sv
// Sequencer for the output-path adder tree: accepts cfg_len operand beats, reduces each
// through the tree, accumulates them and presents one held result per job.
module add_tree_accum_ctrl
  import add_tree_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int SUM_W = DEF_SUM_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic                 clk,
  input logic                 rst,
  add_tree_accum_ctrl_if.slave bus
);

  // A too-narrow SUM_W is widened so a beat's sum can never wrap inside the tree.
  localparam bit SUM_W_OK = sum_w_fits(LANES, IN_W, SUM_W);
  localparam int TREE_W   = SUM_W_OK ? SUM_W : IN_W + $clog2(LANES);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [TREE_W-1:0] tree_sum;
  logic [TREE_W-1:0] sum_q;
  logic              sum_vld;
  logic              sum_first;
  logic [ACC_W-1:0]  acc;
  logic              overflow;
  logic              out_valid_q;
  logic              ready;
  logic              accept;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    acc_sum;

  add_tree_reduce #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .SUM_W (TREE_W)
  ) u_reduce (
    .data (bus.in_data),
    .sum  (tree_sum)
  );

  always_comb begin
    ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    ready = (bus.cfg_len != '0);
        ACCUM:   ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid && ready;

  // The first beat of a job replaces the accumulator instead of adding to it.
  always_comb begin
    acc_base = sum_first ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(sum_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      sum_q       <= '0;
      sum_vld     <= 1'b0;
      sum_first   <= 1'b0;
      acc         <= '0;
      overflow    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_vld <= accept;
      if (accept) begin
        sum_q     <= tree_sum;
        sum_first <= (state == IDLE);
      end

      if (sum_vld) begin
        acc      <= acc_sum[ACC_W-1:0];
        overflow <= (sum_first ? 1'b0 : overflow) | acc_sum[ACC_W];
      end

      case (state)
        IDLE: begin
          if (accept) begin
            len_q <= bus.cfg_len;
            cnt   <= LEN_W'(1);
            state <= (bus.cfg_len == LEN_W'(1)) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state       <= OUT;
          out_valid_q <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = acc;
  assign bus.out_overflow = overflow;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_add_tree_accum_ctrl.sv
// Directed bench for add_tree_accum_ctrl: a default instance plus a 12-bit accumulator
// instance driven in lock-step to exercise the modulo wrap and overflow flag.
module tb_add_tree_accum_ctrl;

  localparam int LANES = 12;
  localparam int IN_W  = 8;
  localparam int DW    = LANES * IN_W;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  add_tree_accum_ctrl_if #(.ACC_W(32)) ba ();
  add_tree_accum_ctrl_if #(.ACC_W(12)) bb ();

  assign bb.cfg_len   = ba.cfg_len;
  assign bb.in_valid  = ba.in_valid;
  assign bb.in_data   = ba.in_data;
  assign bb.out_ready = ba.out_ready;

  add_tree_accum_ctrl #(.ACC_W(32)) u_a (.clk(clk), .rst(rst), .bus(ba.slave));
  add_tree_accum_ctrl #(.ACC_W(12)) u_b (.clk(clk), .rst(rst), .bus(bb.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = 8'(i + 1);
    return r;
  endfunction

  // Presents one beat and returns #1 after the edge on which it was accepted.
  task automatic send_beat(input string tag, input logic [DW-1:0] data);
    logic hs;
    hs = 1'b0;
    ba.in_valid = 1'b1;
    ba.in_data  = data;
    for (int k = 0; k < 50 && !hs; k++) begin
      #1;
      hs = ba.in_ready;
      @(posedge clk);
      #1;
    end
    ba.in_valid = 1'b0;
    check({tag, "_handshake"}, 32'(hs), 32'd1);
  endtask

  // Waits (bounded) for the result, checks it, then consumes it with one out_ready pulse.
  task automatic finish_job(input string tag, input logic [31:0] exp, input logic exp_ovf);
    int waited;
    waited = 0;
    while (!ba.out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, 32'(ba.out_valid), 32'd1);
    check({tag, "_data"}, ba.out_data, exp);
    check({tag, "_ovf"}, 32'(ba.out_overflow), 32'(exp_ovf));
    ba.out_ready = 1'b1;
    tick();
    ba.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(ba.out_valid), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    ba.cfg_len   = 8'd1;
    ba.in_valid  = 1'b0;
    ba.in_data   = '0;
    ba.out_ready = 1'b0;
    repeat (2) tick();

    check("rst_in_ready", 32'(ba.in_ready), 32'd0);
    check("rst_out_valid", 32'(ba.out_valid), 32'd0);
    check("rst_out_data", ba.out_data, 32'd0);
    check("rst_ovf", 32'(ba.out_overflow), 32'd0);
    check("rst_busy", 32'(ba.busy), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(ba.in_ready), 32'd1);

    // 1: single beat, 12 x 255 = 3060; the handshake edge counts as the first of two edges.
    ba.cfg_len = 8'd1;
    send_beat("t1", fill(8'hFF));
    check("t1_busy_drain", 32'(ba.busy), 32'd1);
    check("t1_valid_edge1", 32'(ba.out_valid), 32'd0);
    tick();
    check("t1_valid_edge2", 32'(ba.out_valid), 32'd1);
    finish_job("t1", 32'd3060, 1'b0);

    // 2: four ramp beats, 78 each -> 312; cfg_len change mid-job must be ignored.
    ba.cfg_len = 8'd4;
    for (int b = 0; b < 4; b++) begin
      send_beat("t2", ramp());
      ba.cfg_len = 8'd2;
    end
    ba.in_valid = 1'b1;
    #1;
    check("t2_ready_drain", 32'(ba.in_ready), 32'd0);
    tick();
    check("t2_ready_out", 32'(ba.in_ready), 32'd0);
    ba.in_valid = 1'b0;
    finish_job("t2", 32'd312, 1'b0);

    // 3: three beats of all-ones with 2-cycle gaps carrying junk data -> 36.
    ba.cfg_len = 8'd3;
    for (int b = 0; b < 3; b++) begin
      send_beat("t3", fill(8'h01));
      if (b < 2) begin
        ba.in_data = fill(8'hFF);
        repeat (2) tick();
        check("t3_gap_busy", 32'(ba.busy), 32'd1);
        check("t3_gap_valid", 32'(ba.out_valid), 32'd0);
      end
    end
    finish_job("t3", 32'd36, 1'b0);

    // 4: result held under back-pressure, then the next job starts from a cleared accumulator.
    ba.cfg_len = 8'd2;
    send_beat("t4", fill(8'h03));
    send_beat("t4", fill(8'h03));
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_valid", 32'(ba.out_valid), 32'd1);
      check("t4_hold_data", ba.out_data, 32'd72);
      check("t4_hold_ready", 32'(ba.in_ready), 32'd0);
      check("t4_hold_busy", 32'(ba.busy), 32'd1);
    end
    finish_job("t4", 32'd72, 1'b0);
    ba.cfg_len = 8'd1;
    send_beat("t4b", fill(8'h02));
    finish_job("t4b", 32'd24, 1'b0);

    // 5: 2 x 3060 = 6120 wraps to 2024 in 12 bits with overflow; next job clears it.
    ba.cfg_len = 8'd2;
    send_beat("t5", fill(8'hFF));
    send_beat("t5", fill(8'hFF));
    tick();
    check("t5_b_valid", 32'(bb.out_valid), 32'd1);
    check("t5_b_data", 32'(bb.out_data), 32'd2024);
    check("t5_b_ovf", 32'(bb.out_overflow), 32'd1);
    check("t5_b_ready", 32'(bb.in_ready), 32'd0);
    finish_job("t5", 32'd6120, 1'b0);
    ba.cfg_len = 8'd1;
    send_beat("t5b", fill(8'h01));
    tick();
    check("t5b_b_valid", 32'(bb.out_valid), 32'd1);
    check("t5b_b_data", 32'(bb.out_data), 32'd12);
    check("t5b_b_ovf", 32'(bb.out_overflow), 32'd0);
    check("t5b_b_busy", 32'(bb.busy), 32'd1);
    finish_job("t5b", 32'd12, 1'b0);

    // 6: reset at cnt=2 of 4 discards the job; cfg_len=0 never starts one.
    ba.cfg_len = 8'd4;
    send_beat("t6", fill(8'h01));
    send_beat("t6", fill(8'h01));
    rst = 1'b1;
    tick();
    check("t6_rst_valid", 32'(ba.out_valid), 32'd0);
    check("t6_rst_data", ba.out_data, 32'd0);
    check("t6_rst_ovf", 32'(ba.out_overflow), 32'd0);
    check("t6_rst_busy", 32'(ba.busy), 32'd0);
    check("t6_rst_ready", 32'(ba.in_ready), 32'd0);
    rst         = 1'b0;
    ba.cfg_len  = 8'd0;
    ba.in_valid = 1'b1;
    ba.in_data  = fill(8'h01);
    #1;
    check("t6_len0_ready", 32'(ba.in_ready), 32'd0);
    repeat (4) tick();
    check("t6_len0_busy", 32'(ba.busy), 32'd0);
    check("t6_len0_ready_late", 32'(ba.in_ready), 32'd0);
    check("t6_len0_valid", 32'(ba.out_valid), 32'd0);
    ba.in_valid = 1'b0;
    ba.cfg_len  = 8'd2;
    send_beat("t6_fresh", fill(8'h05));
    send_beat("t6_fresh", fill(8'h05));
    finish_job("t6_fresh", 32'd120, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
